mem_lsu_hs: RTL and testbench

// - Parametrised data-memory LSU: next generation of the single-cycle LSU. Sits between DISPATCHER and WB.
// - Adds a valid/ready request/response handshake with stall-safe response hold, and misaligned, out-of-range
//   and illegal-op fault detection. Also makes memory size and base address parametric.
// - Owns an internal byte-enabled 1R1W word RAM (read-enable gated) and returns LB/LBU/LH/LHU/LW results and store retirements.

---
 rtl/mem_lsu_hs.sv | 191 +++++++++++++++++++
 tb/tb_mem_lsu_hs.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_hs.sv
// Load/store unit with a valid/ready request/response handshake.
// Holds an internal byte-enabled word RAM, detects illegal, misaligned and
// out-of-range accesses, and keeps every response output stable under backpressure.
module mem_lsu_hs #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        req_reg_write,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic        resp_reg_write,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_cause,
  output logic [31:0] resp_fault_addr
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  // Select the addressed byte/half of a RAM word and extend per funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   rdata_q;

  logic [31:0]   addr;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic [1:0]    cause;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic [3:0]    be;
  logic [31:0]   wlanes;

  logic          valid_q, valid_d;
  logic [4:0]    rd_q, rd_d;
  logic          regw_q, regw_d;
  logic          fault_q, fault_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   faddr_q, faddr_d;
  logic          ld_q, ld_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    lo_q, lo_d;

  // Address generation, fault classification, byte enables and lane replication.
  always_comb begin
    addr         = req_base + req_offset;
    off          = addr - BASE_ADDR;
    idx          = off[AW+1:2];
    illegal      = 1'b0;
    if (req_load == req_store)
      illegal = 1'b1;
    else if (req_load && (req_op == 3'b011 || req_op == 3'b110 || req_op == 3'b111))
      illegal = 1'b1;
    else if (req_store && (req_op >= 3'b011))
      illegal = 1'b1;
    misaligned   = ((req_op[1:0] == 2'b01) && addr[0]) ||
                   ((req_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, off} >= MEM_BYTES);
    if (illegal)           cause = CAUSE_ILLEGAL;
    else if (misaligned)   cause = CAUSE_MISALGN;
    else if (out_of_range) cause = CAUSE_RANGE;
    else                   cause = CAUSE_NONE;
    fault        = (cause != CAUSE_NONE);

    req_ready    = ~flush & (~valid_q | resp_ready);
    accept       = req_valid & req_ready;
    wr_en        = accept & req_store & ~fault;
    rd_en        = accept & req_load & ~fault;

    case (req_op[1:0])
      2'b00:   be = 4'b0001 << addr[1:0];
      2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (req_op[1:0])
      2'b00:   wlanes = {4{req_wdata[7:0]}};
      2'b01:   wlanes = {2{req_wdata[15:0]}};
      default: wlanes = req_wdata;
    endcase
  end

  // RAM: byte-enabled write on accepted legal stores; read only on accepted legal loads,
  // so the read register (and thus resp_data) cannot move while a response is held.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
    if (rd_en) rdata_q <= mem[idx];
  end

  // Response next-state: capture on accept, drop on flush or consumption, hold otherwise.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    regw_d  = regw_q;
    fault_d = fault_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    ld_d    = ld_q;
    op_d    = op_q;
    lo_d    = lo_q;
    if (accept) begin
      valid_d = 1'b1;
      rd_d    = req_rd;
      regw_d  = req_reg_write & req_load & ~fault;
      fault_d = fault;
      cause_d = cause;
      faddr_d = fault ? addr : 32'h0;
      ld_d    = req_load & ~fault;
      op_d    = req_op;
      lo_d    = addr[1:0];
    end else if (flush || resp_ready) begin
      valid_d = 1'b0;
    end
  end

  // Response register bank with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= 5'h0;
      regw_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      faddr_q <= 32'h0;
      ld_q    <= 1'b0;
      op_q    <= 3'b000;
      lo_q    <= 2'b00;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      regw_q  <= regw_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
    end
  end

  assign resp_valid       = valid_q;
  assign resp_rd          = rd_q;
  assign resp_reg_write   = regw_q;
  assign resp_fault       = fault_q;
  assign resp_fault_cause = cause_q;
  assign resp_fault_addr  = faddr_q;
  assign resp_data        = ld_q ? load_extend(rdata_q, op_q, lo_q) : 32'h0;

endmodule

// File: tb/tb_mem_lsu_hs.sv
// Directed bench for mem_lsu_hs: data path, byte merge, faults, backpressure, flush, reset.
module tb_mem_lsu_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_base = 32'h0;
  logic [31:0] req_offset = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        req_reg_write = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [4:0]  resp_rd;
  logic        resp_reg_write;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [1:0]  resp_fault_cause;
  logic [31:0] resp_fault_addr;

  int total = 0;
  int bad   = 0;

  mem_lsu_hs #(.MEM_WORDS(4096), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_op(req_op),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_reg_write(req_reg_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_reg_write(resp_reg_write), .resp_data(resp_data),
    .resp_fault(resp_fault), .resp_fault_cause(resp_fault_cause),
    .resp_fault_addr(resp_fault_addr)
  );

  always #5 clk = ~clk;

  // Present one request for a single cycle; the response is visible on return.
  task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                       input logic [31:0] base, input logic [31:0] offs,
                       input logic [31:0] wd, input logic [4:0] rd, input logic rw);
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st; req_op = op;
    req_base = base; req_offset = offs; req_wdata = wd; req_rd = rd; req_reg_write = rw;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", resp_data); end
    total++; if ({resp_fault, resp_reg_write, resp_fault_cause, resp_rd} !== 10'h0) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=0", {resp_fault, resp_reg_write, resp_fault_cause, resp_rd}); end
    total++; if (resp_fault_addr !== 32'h0) begin bad++; $display("FAIL reset_faddr got=%h exp=0", resp_fault_addr); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_datapath();
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 5'd3, 1'b0);
    total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_data !== 32'h0 || resp_reg_write !== 1'b0) begin
      bad++; $display("FAIL sw_resp got v=%b f=%b d=%h rw=%b exp v=1 f=0 d=0 rw=0", resp_valid, resp_fault, resp_data, resp_reg_write); end
    issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h10, 32'h0, 5'd5, 1'b1);
    total++; if (resp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_10 got=%h exp=deadbeef", resp_data); end
    total++; if (resp_rd !== 5'd5 || resp_reg_write !== 1'b1 || resp_valid !== 1'b1) begin
      bad++; $display("FAIL lw_10_ctrl got rd=%0d rw=%b v=%b exp rd=5 rw=1 v=1", resp_rd, resp_reg_write, resp_valid); end
    issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h0, 5'd6, 1'b1);
    total++; if (resp_data !== 32'hFFFFFFDE) begin bad++; $display("FAIL lb_13 got=%h exp=ffffffde", resp_data); end
    issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0, 5'd6, 1'b1);
    total++; if (resp_data !== 32'h000000DE) begin bad++; $display("FAIL lbu_13 got=%h exp=000000de", resp_data); end
    issue(1'b1, 1'b0, 3'b001, 32'h10, 32'h2, 32'h0, 5'd7, 1'b1);
    total++; if (resp_data !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh_12 got=%h exp=ffffdead", resp_data); end
    issue(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0, 5'd7, 1'b1);
    total++; if (resp_data !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_10 got=%h exp=0000beef", resp_data); end
  endtask

  task automatic test_byte_merge();
    issue(1'b0, 1'b1, 3'b000, 32'h11, 32'h0, 32'hAAAAAA55, 5'd0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd8, 1'b1);
    total++; if (resp_data !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge got=%h exp=dead55ef", resp_data); end
    issue(1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 32'hFFFF1234, 5'd0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd8, 1'b1);
    total++; if (resp_data !== 32'h123455EF) begin bad++; $display("FAIL sh_merge got=%h exp=123455ef", resp_data); end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 5'd9, 1'b1);
    total++; if (resp_fault !== 1'b1 || resp_fault_cause !== 2'b01) begin
      bad++; $display("FAIL lw_mis got f=%b c=%b exp f=1 c=01", resp_fault, resp_fault_cause); end
    total++; if (resp_fault_addr !== 32'h12 || resp_reg_write !== 1'b0 || resp_data !== 32'h0) begin
      bad++; $display("FAIL lw_mis_info got a=%h rw=%b d=%h exp a=12 rw=0 d=0", resp_fault_addr, resp_reg_write, resp_data); end
    issue(1'b0, 1'b1, 3'b001, 32'h13, 32'h0, 32'h0000BBBB, 5'd0, 1'b0);
    total++; if (resp_fault_cause !== 2'b01 || resp_fault_addr !== 32'h13) begin
      bad++; $display("FAIL sh_mis got c=%b a=%h exp c=01 a=13", resp_fault_cause, resp_fault_addr); end
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd9, 1'b1);
    total++; if (resp_data !== 32'h123455EF) begin bad++; $display("FAIL sh_mis_nowrite got=%h exp=123455ef", resp_data); end
  endtask

  task automatic test_range_illegal();
    issue(1'b1, 1'b0, 3'b010, 32'h3FFC, 32'h4, 32'h0, 5'd1, 1'b1);
    total++; if (resp_fault_cause !== 2'b10 || resp_fault_addr !== 32'h4000 || resp_reg_write !== 1'b0) begin
      bad++; $display("FAIL lw_range got c=%b a=%h rw=%b exp c=10 a=4000 rw=0", resp_fault_cause, resp_fault_addr, resp_reg_write); end
    issue(1'b1, 1'b0, 3'b010, 32'h4002, 32'h0, 32'h0, 5'd1, 1'b1);
    total++; if (resp_fault_cause !== 2'b01) begin bad++; $display("FAIL prio_mis_range got=%b exp=01", resp_fault_cause); end
    issue(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 5'd1, 1'b1);
    total++; if (resp_fault_cause !== 2'b11 || resp_fault !== 1'b1) begin
      bad++; $display("FAIL both_set got c=%b f=%b exp c=11 f=1", resp_fault_cause, resp_fault); end
    issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd1, 1'b1);
    total++; if (resp_fault_cause !== 2'b11) begin bad++; $display("FAIL none_set got=%b exp=11", resp_fault_cause); end
    issue(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd1, 1'b1);
    total++; if (resp_fault_cause !== 2'b11) begin bad++; $display("FAIL ld_op011 got=%b exp=11", resp_fault_cause); end
    issue(1'b0, 1'b1, 3'b011, 32'h13, 32'h0, 32'h0, 5'd1, 1'b0);
    total++; if (resp_fault_cause !== 2'b11) begin bad++; $display("FAIL prio_ill_mis got=%b exp=11", resp_fault_cause); end
    issue(1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd0, 1'b0);
    total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL wrap_store got f=%b exp=0", resp_fault); end
    issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 5'd2, 1'b1);
    total++; if (resp_data !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_load got=%h exp=cafef00d", resp_data); end
  endtask

  task automatic test_backpressure();
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd11, 1'b1);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_op = 3'b010;
    req_base = 32'h4; req_offset = 32'h0; req_rd = 5'd12; req_reg_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1 || resp_data !== 32'h123455EF || resp_rd !== 5'd11 || resp_reg_write !== 1'b1) begin
        bad++; $display("FAIL hold_%0d got v=%b d=%h rd=%0d exp v=1 d=123455ef rd=11", i, resp_valid, resp_data, resp_rd); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%b exp=0", i, req_ready); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'hCAFEF00D || resp_rd !== 5'd12) begin
      bad++; $display("FAIL release_resp got v=%b d=%h rd=%0d exp v=1 d=cafef00d rd=12", resp_valid, resp_data, resp_rd); end
  endtask

  task automatic test_flush();
    issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h0BADC0DE, 5'd0, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    flush = 1'b1;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_op = 3'b010;
    req_base = 32'h10; req_offset = 32'h0; req_rd = 5'd13;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", resp_valid); end
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 5'd14, 1'b1);
    total++; if (resp_data !== 32'h0BADC0DE) begin bad++; $display("FAIL flush_store_kept got=%h exp=0badc0de", resp_data); end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 5'd15, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_rd !== 5'd0) begin
      bad++; $display("FAIL async_reset got v=%b d=%h rd=%0d exp v=0 d=0 rd=0", resp_valid, resp_data, resp_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 5'd16, 1'b1);
    total++; if (resp_data !== 32'h123455EF) begin bad++; $display("FAIL after_reset_ram got=%h exp=123455ef", resp_data); end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_byte_merge();
    test_misaligned();
    test_range_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
